// File: rtl/tick_receiver.sv
// tick_receiver
//   Receives an asynchronous, active-low tick strobe and brings it into the
//   clk domain. Each falling edge of the synchronised (optionally filtered)
//   level counts as one tick event. Events queue in a saturating pending
//   counter, which the consumer drains with take.
//
//   Optional feature macro: TICKRX_FILTER_EN
//     When defined, a glitch filter sits between the last synchroniser stage
//     and the edge detector. The level changes only after FILT_LEN consecutive
//     equal samples.
//
// Parameters
//   SYNC_STAGES  synchroniser depth (>= 2)
//   CNT_WIDTH    pending counter width; saturates at 2**CNT_WIDTH-1
//   FILT_LEN     glitch filter length (>= 2); used only with TICKRX_FILTER_EN
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   tick_n    in   asynchronous active-low tick strobe, idles high
//   take      in   consumer acknowledge; removes one pending event
//   stb       out  one-cycle pulse per accepted tick
//   evt       out  high while pending != 0
//   pending   out  count of unconsumed events
//   overflow  out  sticky; set when a tick arrives with pending at maximum
module tick_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 4,
  parameter int unsigned FILT_LEN    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_n,
  input  logic                 take,
  output logic                 stb,
  output logic                 evt,
  output logic [CNT_WIDTH-1:0] pending,
  output logic                 overflow
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("tick_receiver: SYNC_STAGES must be at least 2");
  end
  if (FILT_LEN < 2) begin : g_bad_filt
    $error("tick_receiver: FILT_LEN must be at least 2");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_stb;
  logic [CNT_WIDTH-1:0]   r_pending;
  logic                   r_overflow;
  logic                   w_sn;
  logic                   w_level;
  logic                   w_acc;
  logic                   w_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tick_n};
    end
  end

  assign w_sn = r_sync[SYNC_STAGES-1];

`ifdef TICKRX_FILTER_EN
  // r_hist keeps the previous FILT_LEN-1 values of sN. Together with the
  // current sN it forms a FILT_LEN-sample window. The filtered level is
  // resolved combinationally from that window. It falls back to the last
  // resolved level, which r_prev already holds. This gives exactly
  // FILT_LEN-1 cycles of added latency.
  logic [FILT_LEN-2:0] r_hist;
  logic [FILT_LEN-1:0] w_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= '0;
    end else begin
      r_hist[0] <= w_sn;
      for (int unsigned i = 1; i < FILT_LEN - 1; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
    end
  end

  assign w_win = {r_hist, w_sn};

  always_comb begin
    w_level = r_prev;
    if (&w_win) begin
      w_level = 1'b1;
    end else if (~|w_win) begin
      w_level = 1'b0;
    end
  end
`else
  assign w_level = w_sn;
`endif

  // r_prev resets low, so a level held low through reset is never counted.
  assign w_acc  = r_prev & ~w_level;
  assign w_take = take & evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev     <= 1'b0;
      r_stb      <= 1'b0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_prev <= w_level;
      r_stb  <= w_acc;
      if (w_acc && !w_take) begin
        if (&r_pending) begin
          r_overflow <= 1'b1;
        end else begin
          r_pending <= r_pending + CNT_WIDTH'(1);
        end
      end else if (w_take && !w_acc) begin
        r_pending <= r_pending - CNT_WIDTH'(1);
      end
    end
  end

  assign stb      = r_stb;
  assign evt      = |r_pending;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_tick_receiver.sv
module tb_tick_receiver;

  localparam int N = 2;
`ifdef TICKRX_FILTER_EN
  localparam int F        = 3;
  localparam int STB_EDGE = N + F;
`else
  localparam int F        = 1;
  localparam int STB_EDGE = N + 1;
`endif

  logic clk = 1'b0;
  logic rst, tick_n, take;

  logic       d_stb, d_evt, d_ovf;
  logic [3:0] d_pend;
  logic       s_stb, s_evt, s_ovf;
  logic [1:0] s_pend;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  tick_receiver u_dut (
    .clk(clk), .rst(rst), .tick_n(tick_n), .take(take),
    .stb(d_stb), .evt(d_evt), .pending(d_pend), .overflow(d_ovf)
  );

  tick_receiver #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst(rst), .tick_n(tick_n), .take(take),
    .stb(s_stb), .evt(s_evt), .pending(s_pend), .overflow(s_ovf)
  );

  // Reference model. It works on the stream of tick_n samples taken since
  // the last reset. sN after edge e is sample e-N, or 0 before that sample
  // exists. The level is sN, or the window-resolved value when the filter is
  // present. A tick is a 1->0 step of the level between consecutive cycles.
  bit         q[$];
  bit         lv[$];
  logic       m_stb;
  logic [3:0] m_pd;
  logic [1:0] m_ps;
  logic       m_od, m_os;

  function automatic bit sn_at(int k);
    if (k < N) return 1'b0;
    return q[k-N];
  endfunction

  function automatic bit new_level(int k, bit last);
    int ones = 0;
    for (int j = 0; j < F; j++) ones += int'(sn_at(k - j));
    if (ones == F) return 1'b1;
    if (ones == 0) return 1'b0;
    return last;
  endfunction

  always @(posedge clk) begin
    int  e;
    bit  acc, td, ts;
    if (rst) begin
      q.delete(); lv.delete(); lv.push_back(1'b0);
      m_stb = 0; m_pd = 0; m_ps = 0; m_od = 0; m_os = 0;
    end else begin
      e   = lv.size() - 1;
      acc = (e >= 1) && lv[e-1] && !lv[e];
      td  = take && (m_pd != 0);
      ts  = take && (m_ps != 0);
      if (acc && !td) begin
        if (m_pd == 4'hF) m_od = 1; else m_pd = m_pd + 1;
      end else if (td && !acc) m_pd = m_pd - 1;
      if (acc && !ts) begin
        if (m_ps == 2'h3) m_os = 1; else m_ps = m_ps + 1;
      end else if (ts && !acc) m_ps = m_ps - 1;
      m_stb = acc;
      q.push_back(tick_n);
      lv.push_back(new_level(lv.size(), lv[lv.size()-1]));
    end
  end

  logic [11:0] obs, exp_vec;
  assign obs     = {d_stb, d_evt, d_pend, d_ovf, s_stb, s_evt, s_pend, s_ovf};
  assign exp_vec = {m_stb, m_pd != 4'h0, m_pd, m_od, m_stb, m_ps != 2'h0, m_ps, m_os};

  task automatic test_reset();
    rst = 1; tick_n = 1; take = 0;
    repeat (3) @(negedge clk);
    nchk++;
    if (obs !== 12'h000) begin
      nerr++; $display("FAIL reset_state got=%h want=%h", obs, 12'h000);
    end
  endtask

  task automatic test_single_tick();
    int nstb = 0;
    rst = 0; tick_n = 1; take = 0;
    repeat (5) @(negedge clk);
    tick_n = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == F + 2) tick_n = 1;
      nchk++;
      if (d_stb !== (k == STB_EDGE) || obs !== exp_vec) begin
        nerr++;
        $display("FAIL single_latency edge=%0d stb=%b want=%b obs=%h model=%h",
                 k, d_stb, (k == STB_EDGE), obs, exp_vec);
      end
      nstb += int'(d_stb);
    end
    nchk++;
    if (d_pend !== 4'd1 || d_evt !== 1'b1 || nstb != 1) begin
      nerr++; $display("FAIL single_pending pend=%0d evt=%b stbs=%0d want 1 1 1", d_pend, d_evt, nstb);
    end
    take = 1;
    @(negedge clk);
    take = 0;
    nchk++;
    if (d_pend !== 4'd0 || d_evt !== 1'b0) begin
      nerr++; $display("FAIL single_take pend=%0d evt=%b want 0 0", d_pend, d_evt);
    end
  endtask

  task automatic test_held_low();
    int nstb = 0;
    rst = 1; tick_n = 0; take = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (10) begin
      @(negedge clk);
      nstb += int'(d_stb);
    end
    nchk++;
    if (nstb != 0 || d_pend !== 4'd0) begin
      nerr++; $display("FAIL held_low stbs=%0d pend=%0d want 0 0", nstb, d_pend);
    end
    tick_n = 1;
    repeat (6) @(negedge clk);
    tick_n = 0;
    repeat (10) begin
      @(negedge clk);
      nstb += int'(d_stb);
    end
    nchk++;
    if (nstb != 1 || obs !== exp_vec) begin
      nerr++; $display("FAIL held_low_edge stbs=%0d want 1 obs=%h model=%h", nstb, obs, exp_vec);
    end
  endtask

  task automatic test_saturation();
    int nstb = 0;
    rst = 1; tick_n = 1; take = 0;
    @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    for (int t = 1; t <= 4; t++) begin
      tick_n = 0;
      repeat (4) begin @(negedge clk); nstb += int'(s_stb); end
      tick_n = 1;
      repeat (6) begin @(negedge clk); nstb += int'(s_stb); end
      if (t == 3) begin
        nchk++;
        if (s_pend !== 2'd3 || s_ovf !== 1'b0) begin
          nerr++; $display("FAIL sat_third pend=%0d ovf=%b want 3 0", s_pend, s_ovf);
        end
      end
    end
    nchk++;
    if (s_pend !== 2'd3 || s_ovf !== 1'b1 || nstb != 4 || d_pend !== 4'd4 || d_ovf !== 1'b0) begin
      nerr++;
      $display("FAIL sat_fourth pend=%0d ovf=%b stbs=%0d wide_pend=%0d wide_ovf=%b want 3 1 4 4 0",
               s_pend, s_ovf, nstb, d_pend, d_ovf);
    end
    take = 1;
    repeat (6) @(negedge clk);
    take = 0;
    nchk++;
    if (s_pend !== 2'd0 || s_ovf !== 1'b1 || d_pend !== 4'd0 || obs !== exp_vec) begin
      nerr++; $display("FAIL sat_drain pend=%0d ovf=%b obs=%h model=%h", s_pend, s_ovf, obs, exp_vec);
    end
  endtask

  task automatic one_tick();
    tick_n = 0;
    repeat (4) @(negedge clk);
    tick_n = 1;
    repeat (6) @(negedge clk);
  endtask

  // Lines take up with the edge that registers the accept.
  task automatic tick_with_take(output logic stb_seen);
    tick_n = 0;
    repeat (STB_EDGE - 1) @(negedge clk);
    take = 1;
    @(negedge clk);
    take = 0;
    stb_seen = s_stb;
    repeat (4 - STB_EDGE + 1 > 0 ? 4 - STB_EDGE + 1 : 1) @(negedge clk);
    tick_n = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic st;
    rst = 1; tick_n = 1; take = 0;
    @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    one_tick();
    one_tick();
    tick_with_take(st);
    nchk++;
    if (st !== 1'b1 || s_pend !== 2'd2 || d_pend !== 4'd2) begin
      nerr++; $display("FAIL simul_two stb=%b pend=%0d wide=%0d want 1 2 2", st, s_pend, d_pend);
    end
    one_tick();
    tick_with_take(st);
    nchk++;
    if (st !== 1'b1 || s_pend !== 2'd3 || s_ovf !== 1'b0 || obs !== exp_vec) begin
      nerr++; $display("FAIL simul_max stb=%b pend=%0d ovf=%b want 1 3 0", st, s_pend, s_ovf);
    end
  endtask

  task automatic test_take_empty();
    rst = 1; tick_n = 1; take = 0;
    @(negedge clk);
    rst = 0;
    take = 1;
    repeat (3) begin
      @(negedge clk);
      nchk++;
      if (d_pend !== 4'd0 || s_pend !== 2'd0 || d_evt !== 1'b0) begin
        nerr++; $display("FAIL take_empty pend=%0d sat=%0d evt=%b want 0 0 0", d_pend, s_pend, d_evt);
      end
    end
    take = 0;
  endtask

`ifdef TICKRX_FILTER_EN
  task automatic test_filter();
    int nstb = 0;
    rst = 1; tick_n = 1; take = 0;
    @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    tick_n = 0;
    repeat (2) @(negedge clk);
    tick_n = 1;
    repeat (10) begin @(negedge clk); nstb += int'(d_stb); end
    nchk++;
    if (nstb != 0) begin
      nerr++; $display("FAIL filter_glitch stbs=%0d want 0", nstb);
    end
    tick_n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 4) tick_n = 1;
      nchk++;
      if (d_stb !== (k == 5)) begin
        nerr++; $display("FAIL filter_pulse edge=%0d stb=%b want=%b", k, d_stb, (k == 5));
      end
    end
  endtask
`endif

  task automatic test_random();
    int left;
    rst = 1; tick_n = 1; take = 0;
    @(negedge clk);
    rst = 0;
    left = 0;
    for (int c = 0; c < 600; c++) begin
      if (left == 0) begin
        tick_n = ~tick_n;
        left   = int'($urandom_range(1, 6));
      end
      left--;
      take = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      nchk++;
      if (obs !== exp_vec) begin
        nerr++; $display("FAIL random cycle=%0d obs=%h model=%h", c, obs, exp_vec);
      end
    end
    rst = 0; take = 0;
  endtask

  initial begin
    rst = 1; tick_n = 1; take = 0;
    test_reset();
    test_single_tick();
    test_held_low();
    test_saturation();
    test_simultaneous();
    test_take_empty();
`ifdef TICKRX_FILTER_EN
    test_filter();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/tick_receiver.md
# tick_receiver

Clock-domain receiver for the active-low tick strobes produced by edge-gated pulse generators. It synchronises an asynchronous `tick_n` input into the local `clk` domain and detects each falling edge as one tick event. Events are queued in a saturating pending counter, and the consumer drains that counter with a `take` handshake. It sits at the consuming end of every cross-domain tick path, for example timer ticks feeding the sequencer.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of synchroniser flops. Legal values are 2 or more.
- `CNT_WIDTH`, default 4: width of the pending-event counter. The maximum count is 2^CNT_WIDTH−1.
- `FILT_LEN`, default 3: number of consecutive equal samples the glitch filter needs. Legal values are 2 or more. Used only when `TICKRX_FILTER_EN` is defined.

Ports:
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `tick_n`  in  1  asynchronous, active-low tick strobe. Idle level is high.
- `take`  in  1  consumer acknowledge. Removes one pending event.
- `stb`  out  1  one-cycle pulse for each accepted tick.
- `evt`  out  1  high whenever `pending` ≠ 0.
- `pending`  out  CNT_WIDTH  number of unconsumed events.
- `overflow`  out  1  sticky flag. Set when a tick arrives while `pending` is already at maximum.

## Operation
- Synchroniser:
  - Stages s1..sN shift `tick_n` in, where N = SYNC_STAGES.
  - `prev` holds the previous value of sN (or of the filtered level when the filter is compiled in).
- Accept condition: `acc` = `prev`==1 && sN==0, i.e. a falling edge.
- Arming:
  - Reset clears the stages, `prev` and the filtered level to 0.
  - A low level held through reset release is therefore not counted.
  - Detection arms only once a high sample has propagated to `prev`.
- Pending counter, decided each cycle:
  - `acc` && !(`take` && `evt`): +1. At maximum the counter holds its value and sets `overflow`.
  - (`take` && `evt`) && !`acc`: −1.
  - Both conditions true: no change. No overflow, even at maximum.
  - `take` while `pending`==0: ignored. No underflow, no error.
- `stb` is registered and equals `acc` from the previous cycle. It fires for every accepted tick, including ticks dropped by saturation.
- `overflow` clears only on `rst`.
- `rst` asserted mid-operation: at the next edge all state clears, including queued events and the synchroniser. Ticks in flight are lost.

## Timing
- Reset values: `stb`=0, `evt`=0, `pending`=0, `overflow`=0.
- Latency, unfiltered:
  - Edge 1 is the first rising edge that samples `tick_n` low.
  - sN goes low after edge SYNC_STAGES.
  - `stb` goes high, and `pending` increments, after edge SYNC_STAGES+1.
  - With the default SYNC_STAGES=2, that is after edge 3.
- `stb` is high for exactly one `clk` cycle per tick.
- `evt` and `pending` are registered and change on the same edge as `stb`.
- `take` is sampled on the rising edge. `pending` decrements at that same edge.
- Minimum tick spacing: `tick_n` must be low for at least 1 clk period and high for at least 1 clk period between ticks. Narrower pulses may be missed. Missing them is legal and is not an error.

## Configuration
- `TICKRX_FILTER_EN` defined:
  - A glitch filter is inserted between sN and the edge detector.
  - The filtered level goes to 0 after FILT_LEN consecutive 0 samples of sN, and to 1 after FILT_LEN consecutive 1 samples. Otherwise it holds.
  - The filter counter and filtered level reset to 0.
  - Added latency is FILT_LEN−1 cycles: `stb` rises after edge SYNC_STAGES+FILT_LEN.
  - Each low or high phase must last at least FILT_LEN clk periods.
- `TICKRX_FILTER_EN` undefined:
  - No filter logic is present.
  - `FILT_LEN` is ignored.
  - Timing is exactly as described in Timing.

## Test plan
Defaults unless stated; filter not compiled unless stated.
- Single tick, latency:
  - Stimulus: release `rst`, hold `tick_n`=1 for 5 cycles, then drive it low for 3 cycles.
  - Required: `stb`=1 only in the cycle after edge 3 of the low phase; `pending`=1, `evt`=1.
  - Then pulse `take` once: `pending`=0, `evt`=0.
- Held low through reset:
  - Stimulus: `tick_n`=0 during and after `rst`, for 10 cycles.
  - Required: `stb` never asserts; `pending`=0.
  - Then drive `tick_n` 1→0: exactly one `stb`.
- Saturation, CNT_WIDTH=2:
  - Stimulus: 4 ticks with no `take`.
  - Required: `pending`=3 after the 3rd tick; `overflow`=1 on the 4th; `stb` pulses 4 times.
  - `overflow` stays 1 after draining the counter to 0.
- Simultaneous accept and take:
  - Stimulus: set `pending`=2, then assert `take` in the same cycle as an accept.
  - Required: `pending` stays 2; with `pending` at max, `overflow` stays 0.
- Take when empty:
  - Stimulus: assert `take` for 3 cycles with `pending`=0.
  - Required: `pending`=0, no wrap to maximum.
- Filter (`TICKRX_FILTER_EN`, FILT_LEN=3):
  - Stimulus: a 2-cycle low glitch.
  - Required: no `stb`.
  - Stimulus: a 4-cycle low pulse.
  - Required: one `stb` after edge 5.
